// File: rtl/riscv_fetch_aligner.sv
// riscv_fetch_aligner: splits word-aligned fetch words into whole 16/32-bit instruction parcels with their PC.
module riscv_fetch_aligner #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid_i,
  input  logic [31:0]           fetch_rdata_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_ready_o,
  output logic                  instr_valid_o,
  output logic [31:0]           instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_is_compressed_o,
  input  logic                  instr_ready_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i
);
  typedef enum logic [1:0] {ALIGNED, HALF16, HALF32, UNALIGNED} state_t;
  state_t state_q, state_d;
  logic [15:0] half_q;
  logic [ADDR_WIDTH-1:0] half_addr_q;
  logic [31:0] w;
  logic [ADDR_WIDTH-1:0] a, a2;
  logic lo_c, hi_c, hs, load, unused_ok;
  assign w = rst ? '0 : fetch_rdata_i;
  assign a = rst ? '0 : fetch_addr_i;
  assign a2 = a + ADDR_WIDTH'(2);
  assign lo_c = w[1:0] != 2'b11;
  assign hi_c = w[17:16] != 2'b11;
  assign unused_ok = ^{branch_addr_i[ADDR_WIDTH-1:2], branch_addr_i[0]};
  always_comb begin
    instr_valid_o = 1'b0;
    fetch_ready_o = 1'b0;
    instr_rdata_o = lo_c ? {16'h0, w[15:0]} : w;
    instr_addr_o = a;
    case (state_q)
      ALIGNED: begin
        instr_valid_o = fetch_valid_i;
        fetch_ready_o = instr_ready_i;
      end
      HALF16: begin
        instr_valid_o = 1'b1;
        instr_rdata_o = {16'h0, half_q};
        instr_addr_o = half_addr_q;
      end
      HALF32: begin
        instr_valid_o = fetch_valid_i;
        instr_rdata_o = {w[15:0], half_q};
        instr_addr_o = half_addr_q;
        fetch_ready_o = instr_ready_i;
      end
      default: begin
        // a 32-bit upper half is captured without a parcel, costing one bubble
        instr_valid_o = fetch_valid_i && hi_c;
        instr_rdata_o = {16'h0, w[31:16]};
        instr_addr_o = a2;
        fetch_ready_o = fetch_valid_i && (hi_c ? instr_ready_i : 1'b1);
      end
    endcase
    if (rst || branch_i) begin
      instr_valid_o = 1'b0;
      fetch_ready_o = 1'b0;
    end
  end
  assign instr_is_compressed_o = instr_rdata_o[1:0] != 2'b11;
  assign hs = instr_valid_o && instr_ready_i;
  assign load = (state_q == ALIGNED && hs && lo_c) || (state_q == HALF32 && hs) ||
                (state_q == UNALIGNED && fetch_ready_o && !hi_c);
  assign state_d = branch_i ? (branch_addr_i[1] ? UNALIGNED : ALIGNED) :
                   load ? (hi_c ? HALF16 : HALF32) :
                   (hs && state_q != ALIGNED) ? ALIGNED : state_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ALIGNED;
      half_q <= '0;
      half_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        half_q <= w[31:16];
        half_addr_q <= a2;
      end
    end
  end
endmodule

// File: tb/tb_riscv_fetch_aligner.sv
// tb_riscv_fetch_aligner: directed plan cases plus random traffic against a halfword-level reference model.
module tb_riscv_fetch_aligner;
  logic clk = 1'b0, rst = 1'b1;
  logic fv = 1'b0, ir = 1'b0, br = 1'b0;
  logic [31:0] w = '0, a = '0, ba = '0;
  logic fr, iv, ic;
  logic [31:0] id, ia;
  int checks = 0, errors = 0;
  bit m_skip = 0, m_have = 0;
  logic [15:0] m_half = '0;
  logic [31:0] m_addr = '0;
  logic e_v, e_fr, e_frchk;
  logic [31:0] e_d, e_a;
  logic [31:0] fp = '0;

  riscv_fetch_aligner #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .fetch_valid_i(fv), .fetch_rdata_i(w), .fetch_addr_i(a),
    .fetch_ready_o(fr), .instr_valid_o(iv), .instr_rdata_o(id), .instr_addr_o(ia),
    .instr_is_compressed_o(ic), .instr_ready_i(ir), .branch_i(br), .branch_addr_i(ba)
  );

  always #5 clk = ~clk;

  function automatic bit c16(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model view: an optional pending halfword and a flag saying the next word's low half is skipped.
  task automatic expect_now();
    e_v = 0; e_fr = 0; e_frchk = 1; e_d = '0; e_a = '0;
    if (rst || br) begin
    end else if (m_skip) begin
      e_d = {16'h0, w[31:16]}; e_a = a + 32'd2;
      if (!fv) e_frchk = 0;
      else if (c16(w[31:16])) begin e_v = 1; e_fr = ir; end
      else e_fr = 1;
    end else if (m_have) begin
      e_a = m_addr;
      if (c16(m_half)) begin e_v = 1; e_d = {16'h0, m_half}; end
      else begin e_v = fv; e_d = {w[15:0], m_half}; e_fr = ir; end
    end else begin
      e_v = fv; e_a = a; e_fr = ir;
      e_d = c16(w[15:0]) ? {16'h0, w[15:0]} : w;
    end
  endtask

  task automatic set(input logic v, input logic [31:0] wd, input logic [31:0] ad,
                     input logic r, input logic b, input logic [31:0] bad);
    fv = v; w = wd; a = ad; ir = r; br = b; ba = bad;
    #1;
    expect_now();
    chk("valid", {31'b0, iv}, {31'b0, e_v});
    if (e_frchk) chk("fetch_ready", {31'b0, fr}, {31'b0, e_fr});
    if (e_v) begin
      chk("rdata", id, e_d);
      chk("addr", ia, e_a);
      chk("compressed", {31'b0, ic}, {31'b0, e_d[1:0] != 2'b11});
    end
  endtask

  task automatic adv();
    bit n_skip = m_skip, n_have = m_have;
    logic [15:0] n_half = m_half;
    logic [31:0] n_addr = m_addr;
    if (rst) begin n_skip = 0; n_have = 0; end
    else if (br) begin n_skip = ba[1]; n_have = 0; end
    else if (m_skip) begin
      if (fv && c16(w[31:16]) && ir) n_skip = 0;
      else if (fv && !c16(w[31:16])) begin n_skip = 0; n_have = 1; n_half = w[31:16]; n_addr = a + 32'd2; end
    end else if (m_have && c16(m_half)) begin
      if (ir) n_have = 0;
    end else if (fv && ir && (m_have || c16(w[15:0]))) begin
      n_have = 1; n_half = w[31:16]; n_addr = a + 32'd2;
    end
    @(posedge clk);
    m_skip = n_skip; m_have = n_have; m_half = n_half; m_addr = n_addr;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    set(1, 32'h00500093, 32'h100, 1, 0, 0);
    chk("reset_valid", {31'b0, iv}, 32'd0);
    chk("reset_ready", {31'b0, fr}, 32'd0);
    adv();
    rst = 0;
    set(1, 32'h00500093, 32'h100, 1, 0, 0);
    chk("s32_a", id, 32'h00500093); chk("s32_a_pc", ia, 32'h100); chk("s32_a_fr", {31'b0, fr}, 32'd1);
    adv();
    set(1, 32'h00A00113, 32'h104, 1, 0, 0);
    chk("s32_b", id, 32'h00A00113); chk("s32_b_pc", ia, 32'h104); chk("s32_b_fr", {31'b0, fr}, 32'd1);
    adv();
    set(1, 32'h45814501, 32'h200, 1, 0, 0);
    chk("c2_a", id, 32'h00004501); chk("c2_a_pc", ia, 32'h200);
    adv();
    set(0, 32'h0, 32'h204, 1, 0, 0);
    chk("c2_b", id, 32'h00004581); chk("c2_b_pc", ia, 32'h202); chk("c2_b_fr", {31'b0, fr}, 32'd0);
    adv();
    set(0, 32'h0, 32'h204, 1, 0, 0);
    chk("c2_after", {31'b0, iv}, 32'd0);
    adv();
    set(1, 32'h00934501, 32'h300, 1, 0, 0);
    chk("st_a", id, 32'h00004501);
    adv();
    set(1, 32'h12340093, 32'h304, 1, 0, 0);
    chk("st_b", id, 32'h00930093); chk("st_b_pc", ia, 32'h302);
    adv();
    set(0, 32'h0, 32'h308, 1, 0, 0);
    chk("st_c", id, 32'h00001234); chk("st_c_pc", ia, 32'h306);
    adv();
    set(0, 32'h0, 32'h308, 1, 1, 32'h402);
    chk("br_valid", {31'b0, iv}, 32'd0); chk("br_fr", {31'b0, fr}, 32'd0);
    adv();
    set(1, 32'h00934501, 32'h400, 1, 0, 0);
    chk("ua_bubble_v", {31'b0, iv}, 32'd0); chk("ua_bubble_fr", {31'b0, fr}, 32'd1);
    adv();
    set(1, 32'h5678ABCD, 32'h404, 1, 0, 0);
    chk("ua_h32", id, 32'hABCD0093); chk("ua_h32_pc", ia, 32'h402);
    adv();
    for (int i = 0; i < 3; i++) begin
      set(0, 32'h0, 32'h408, 0, 0, 0);
      chk("bp_hold", id, 32'h00005678); chk("bp_pc", ia, 32'h406); chk("bp_fr", {31'b0, fr}, 32'd0);
      adv();
    end
    set(0, 32'h0, 32'h408, 1, 0, 0);
    chk("bp_accept", {31'b0, iv}, 32'd1);
    adv();
    set(1, 32'hFFFF0001, 32'h500, 1, 0, 0);
    adv();
    set(1, 32'h11112222, 32'h504, 1, 1, 32'h600);
    chk("brh32_v", {31'b0, iv}, 32'd0); chk("brh32_fr", {31'b0, fr}, 32'd0);
    adv();
    set(1, 32'h00000013, 32'h600, 1, 0, 0);
    chk("brh32_next", id, 32'h00000013); chk("brh32_pc", ia, 32'h600);
    adv();
    set(1, 32'hFFFF0001, 32'h700, 1, 0, 0);
    adv();
    rst = 1;
    set(1, 32'h22220093, 32'h704, 1, 0, 0);
    chk("rst_mid_v", {31'b0, iv}, 32'd0);
    adv();
    rst = 0;
    set(1, 32'h00500093, 32'h800, 1, 0, 0);
    chk("rst_after", id, 32'h00500093); chk("rst_after_pc", ia, 32'h800);
    adv();
    set(1, 32'h00010001, 32'hFFFFFFFC, 1, 0, 0);
    adv();
    set(0, 32'h0, 32'h0, 1, 0, 0);
    chk("top_pc", ia, 32'hFFFFFFFE);
    adv();
    fp = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      logic r_b = ($urandom_range(0, 99) < 5);
      logic [31:0] r_ba = $urandom & 32'hFFFF_FFFE;
      rst = ($urandom_range(0, 199) == 0);
      set($urandom_range(0, 3) != 0, $urandom, fp, $urandom_range(0, 4) != 0, r_b, r_ba);
      if (!rst && br) fp = ba & 32'hFFFF_FFFC;
      else if (!rst && fv && e_fr && e_frchk) fp = fp + 32'd4;
      adv();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
